// File: rtl/fetch_unit.sv
// fetch_unit: AAP instruction fetch stage.
// Drives a word address to a synchronous instruction memory with 1-cycle read
// latency. Returned 16-bit words are assembled into 16- or 32-bit instructions,
// and each instruction is presented to decode together with its PC.
// Supports a downstream stall (rewind and re-fetch), branch redirect with flush,
// and a configurable reset vector.
// Optional feature macro: FETCH_LONG_INSN_EN. When it is defined, a word with
// bit 15 set starts a 32-bit instruction. When it is undefined, every word is a
// short instruction.

module fetch_unit #(
    parameter int unsigned          PC_WIDTH     = 20,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = {PC_WIDTH{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall_in,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rdata,
    output logic [31:0]         insn_out,
    output logic [PC_WIDTH-1:0] insn_pc,
    output logic                insn_long,
    output logic                insn_valid
);

    localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Issue side: next address to present, and the word expected back this cycle.
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                req_valid_q;
    logic [PC_WIDTH-1:0] req_pc_q;

    // Registered decode-facing outputs.
    logic [15:0]         insn_lo_q;
    logic [PC_WIDTH-1:0] insn_pc_q;
    logic                insn_valid_q;

`ifdef FETCH_LONG_INSN_EN
    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t              state_q;
    logic [15:0]         lo_word_q;
    logic [PC_WIDTH-1:0] lo_pc_q;
    logic [15:0]         insn_hi_q;
    logic                insn_long_q;
`endif

    // Next issue address: a branch redirects, a stall rewinds to the discarded word,
    // and otherwise the address advances (wrapping modulo 2^PC_WIDTH).
    always_comb begin
        pc_d = pc_q;
        if (branch_valid) begin
            pc_d = branch_target;
        end else if (stall_in) begin
            if (req_valid_q) begin
                pc_d = req_pc_q;
            end else begin
                pc_d = pc_q;
            end
        end else begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // Fetch/assembly state machine. Priority: reset, then branch, then stall, then normal flow.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            req_valid_q  <= 1'b0;
            req_pc_q     <= PC_ZERO;
            insn_lo_q    <= 16'h0000;
            insn_pc_q    <= PC_ZERO;
            insn_valid_q <= 1'b0;
`ifdef FETCH_LONG_INSN_EN
            state_q      <= ST_FIRST;
            lo_word_q    <= 16'h0000;
            lo_pc_q      <= PC_ZERO;
            insn_hi_q    <= 16'h0000;
            insn_long_q  <= 1'b0;
`endif
        end else if (branch_valid) begin
            // The arriving word and any half-assembled instruction are dropped.
            pc_q         <= pc_d;
            req_valid_q  <= 1'b0;
            insn_valid_q <= 1'b0;
`ifdef FETCH_LONG_INSN_EN
            state_q      <= ST_FIRST;
`endif
        end else if (stall_in) begin
            // Outputs and assembly state hold, and the arriving word is re-fetched later.
            pc_q         <= pc_d;
            req_valid_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= pc_q;
            req_valid_q  <= 1'b1;
            if (req_valid_q) begin
`ifdef FETCH_LONG_INSN_EN
                case (state_q)
                    ST_FIRST: begin
                        if (imem_rdata[15]) begin
                            lo_word_q    <= imem_rdata;
                            lo_pc_q      <= req_pc_q;
                            state_q      <= ST_SECOND;
                            insn_valid_q <= 1'b0;
                        end else begin
                            insn_lo_q    <= imem_rdata;
                            insn_hi_q    <= 16'h0000;
                            insn_pc_q    <= req_pc_q;
                            insn_long_q  <= 1'b0;
                            insn_valid_q <= 1'b1;
                        end
                    end
                    ST_SECOND: begin
                        // Bit 15 of the second half carries no meaning.
                        insn_lo_q    <= lo_word_q;
                        insn_hi_q    <= imem_rdata;
                        insn_pc_q    <= lo_pc_q;
                        insn_long_q  <= 1'b1;
                        insn_valid_q <= 1'b1;
                        state_q      <= ST_FIRST;
                    end
                    default: begin
                        state_q      <= ST_FIRST;
                        insn_valid_q <= 1'b0;
                    end
                endcase
`else
                insn_lo_q    <= imem_rdata;
                insn_pc_q    <= req_pc_q;
                insn_valid_q <= 1'b1;
`endif
            end else begin
                insn_valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign insn_pc    = insn_pc_q;
    assign insn_valid = insn_valid_q;
`ifdef FETCH_LONG_INSN_EN
    assign insn_out   = {insn_hi_q, insn_lo_q};
    assign insn_long  = insn_long_q;
`else
    assign insn_out   = {16'h0000, insn_lo_q};
    assign insn_long  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard queue per DUT holds expected
// instructions. Monitors pop and compare every instruction accepted by decode
// (insn_valid with stall_in low). Directed checks cover reset values, latency,
// stall hold and branch flush.
// The expectations follow the FETCH_LONG_INSN_EN build setting.

module tb_fetch_unit;

    localparam int PW = 20;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [31:0]   insn;
        logic          lng;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall_in;
    logic          branch_valid;
    logic [PW-1:0] branch_target;
    logic [PW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic [31:0]   insn_out;
    logic [PW-1:0] insn_pc;
    logic          insn_long;
    logic          insn_valid;

    // Second instance: reset vector near the top of the address space.
    logic          w_reset;
    logic          w_stall_in;
    logic          w_branch_valid;
    logic [PW-1:0] w_branch_target;
    logic [PW-1:0] w_imem_addr;
    logic [15:0]   w_imem_rdata;
    logic [31:0]   w_insn_out;
    logic [PW-1:0] w_insn_pc;
    logic          w_insn_long;
    logic          w_insn_valid;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];
    exp_t w_exp_q[$];
    exp_t e1;
    exp_t e2;

    always #5 clock = ~clock;

    fetch_unit #(.PC_WIDTH(PW), .RESET_VECTOR(20'h00000)) dut (
        .clock(clock), .reset(reset), .stall_in(stall_in),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .insn_out(insn_out), .insn_pc(insn_pc),
        .insn_long(insn_long), .insn_valid(insn_valid)
    );

    fetch_unit #(.PC_WIDTH(PW), .RESET_VECTOR(20'hFFFFE)) dut_w (
        .clock(clock), .reset(w_reset), .stall_in(w_stall_in),
        .branch_valid(w_branch_valid), .branch_target(w_branch_target),
        .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .insn_out(w_insn_out), .insn_pc(w_insn_pc),
        .insn_long(w_insn_long), .insn_valid(w_insn_valid)
    );

    // Memory image: a few hand-placed words, otherwise {0, addr[14:0]} (always short).
    function automatic logic [15:0] mem_word(input logic [PW-1:0] a);
        case (a)
            20'h00000: mem_word = 16'h0001;
            20'h00001: mem_word = 16'h0002;
            20'h00002: mem_word = 16'h0003;
            20'h00003: mem_word = 16'h0004;
            20'h00004: mem_word = 16'h8012;
            20'h00005: mem_word = 16'h1234;
            20'h00008: mem_word = 16'h8088;
            default:   mem_word = {1'b0, a[14:0]};
        endcase
    endfunction

    // Synchronous memories with one cycle of read latency.
    always @(posedge clock) begin
        imem_rdata   <= mem_word(imem_addr);
        w_imem_rdata <= mem_word(w_imem_addr);
    end

    function automatic exp_t mk(input logic [PW-1:0] pc, input logic [31:0] insn, input logic lng);
        exp_t r;
        r.pc   = pc;
        r.insn = insn;
        r.lng  = lng;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clock) begin
        if (insn_valid === 1'b1 && stall_in === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_main_unexpected: got pc=%h insn=%h long=%b, expected nothing",
                         insn_pc, insn_out, insn_long);
            end else begin
                e1 = exp_q.pop_front();
                if (insn_pc !== e1.pc || insn_out !== e1.insn || insn_long !== e1.lng) begin
                    n_err++;
                    $display("FAIL sb_main: got pc=%h insn=%h long=%b, expected pc=%h insn=%h long=%b",
                             insn_pc, insn_out, insn_long, e1.pc, e1.insn, e1.lng);
                end
            end
        end
    end

    // Scoreboard monitor for the wrap-around instance.
    always @(negedge clock) begin
        if (w_insn_valid === 1'b1 && w_stall_in === 1'b0) begin
            n_checks++;
            if (w_exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_wrap_unexpected: got pc=%h insn=%h, expected nothing",
                         w_insn_pc, w_insn_out);
            end else begin
                e2 = w_exp_q.pop_front();
                if (w_insn_pc !== e2.pc || w_insn_out !== e2.insn || w_insn_long !== e2.lng) begin
                    n_err++;
                    $display("FAIL sb_wrap: got pc=%h insn=%h long=%b, expected pc=%h insn=%h long=%b",
                             w_insn_pc, w_insn_out, w_insn_long, e2.pc, e2.insn, e2.lng);
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        stall_in        = 1'b0;
        branch_valid    = 1'b0;
        branch_target   = 20'h00000;
        w_reset         = 1'b1;
        w_stall_in      = 1'b0;
        w_branch_valid  = 1'b0;
        w_branch_target = 20'h00000;

        // Expected accepted instructions, main instance, in order.
        exp_q.push_back(mk(20'h00000, 32'h00000001, 1'b0));
        exp_q.push_back(mk(20'h00001, 32'h00000002, 1'b0));
        exp_q.push_back(mk(20'h00002, 32'h00000003, 1'b0));
        exp_q.push_back(mk(20'h00003, 32'h00000004, 1'b0));
`ifdef FETCH_LONG_INSN_EN
        exp_q.push_back(mk(20'h00004, 32'h12348012, 1'b1));
`else
        exp_q.push_back(mk(20'h00004, 32'h00008012, 1'b0));
        exp_q.push_back(mk(20'h00005, 32'h00001234, 1'b0));
`endif
        exp_q.push_back(mk(20'h00006, 32'h00000006, 1'b0));
        exp_q.push_back(mk(20'h00007, 32'h00000007, 1'b0));
        exp_q.push_back(mk(20'h00100, 32'h00000100, 1'b0));
        exp_q.push_back(mk(20'h00101, 32'h00000101, 1'b0));
        exp_q.push_back(mk(20'h00102, 32'h00000102, 1'b0));
        exp_q.push_back(mk(20'h00000, 32'h00000001, 1'b0));
        exp_q.push_back(mk(20'h00001, 32'h00000002, 1'b0));
        exp_q.push_back(mk(20'h00002, 32'h00000003, 1'b0));
        exp_q.push_back(mk(20'h00003, 32'h00000004, 1'b0));

        // Expected accepted instructions, wrap-around instance.
        w_exp_q.push_back(mk(20'hFFFFE, 32'h00007FFE, 1'b0));
        w_exp_q.push_back(mk(20'hFFFFF, 32'h00007FFF, 1'b0));
        w_exp_q.push_back(mk(20'h00000, 32'h00000001, 1'b0));

        repeat (3) @(posedge clock);
        #1;

        // Cycle c = 0 is the first cycle with reset deasserted.
        for (int c = 0; c <= 30; c++) begin
            reset         = (c == 19) || (c >= 25);
            w_reset       = (c >= 4);
            stall_in      = ((c >= 4) && (c <= 6)) || (c == 14);
            branch_valid  = (c == 14);
            branch_target = 20'h00100;
            @(negedge clock);
            case (c)
                0: begin
                    check("reset_valid", 64'(insn_valid), 64'h0);
                    check("reset_out", 64'(insn_out), 64'h0);
                    check("reset_pc", 64'(insn_pc), 64'h0);
                    check("reset_long", 64'(insn_long), 64'h0);
                    check("reset_addr", 64'(imem_addr), 64'h0);
                    check("reset_addr_wrap", 64'(w_imem_addr), 64'hFFFFE);
                end
                1: check("c1_not_valid", 64'(insn_valid), 64'h0);
                2: check("c2_first_valid", 64'({insn_valid, insn_pc}), 64'({1'b1, 20'h00000}));
                5, 6, 7: check("stall_hold", 64'({insn_valid, insn_pc, insn_out}),
                               64'({1'b1, 20'h00002, 32'h00000003}));
                8: check("stall_release_gap", 64'(insn_valid), 64'h0);
`ifdef FETCH_LONG_INSN_EN
                10: check("long_pre_gap", 64'(insn_valid), 64'h0);
                11: check("long_valid", 64'({insn_valid, insn_long, insn_pc}),
                          64'({1'b1, 1'b1, 20'h00004}));
`else
                10: check("short_bit15", 64'({insn_valid, insn_long, insn_pc}),
                          64'({1'b1, 1'b0, 20'h00004}));
`endif
                15, 16: check("branch_flush", 64'(insn_valid), 64'h0);
                17: check("branch_target_valid", 64'({insn_valid, insn_pc}), 64'({1'b1, 20'h00100}));
                20: begin
                    check("midreset_outputs", 64'({insn_valid, insn_long, insn_pc, insn_out}), 64'h0);
                    check("midreset_addr", 64'(imem_addr), 64'h0);
                end
                22: check("restart_valid", 64'({insn_valid, insn_pc}), 64'({1'b1, 20'h00000}));
                default: ;
            endcase
            @(posedge clock);
            #1;
        end

        check("sb_main_drained", 64'(exp_q.size()), 64'h0);
        check("sb_wrap_drained", 64'(w_exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage for the AAP pipeline. It drives a word address to a synchronous instruction memory and assembles the returned 16-bit words into complete 16- or 32-bit instructions. Each instruction is presented to decode with its PC. Supports downstream stall, branch redirect with flush, and a configurable reset vector and address width.

## Interface
Parameters:
- PC_WIDTH, 20, width of word address / PC
- RESET_VECTOR, 0, PC loaded on reset (PC_WIDTH bits)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall_in  input  1  decode not accepting; hold outputs
- branch_valid  input  1  redirect fetch this cycle
- branch_target  input  PC_WIDTH  redirect word address
- imem_addr  output  PC_WIDTH  word address to instruction memory (driven directly from pc register)
- imem_rdata  input  16  memory word for address presented on previous cycle
- insn_out  output  32  instruction; {second_word, first_word} for long, {16'h0, word} for short
- insn_pc  output  PC_WIDTH  address of first word of insn_out
- insn_long  output  1  insn_out is a 32-bit instruction
- insn_valid  output  1  insn_out/insn_pc/insn_long valid

## Operation
- Registers: pc (next issue address), req_valid/req_pc (word arriving this cycle), state {FIRST, SECOND}, lo_word, lo_pc, and the registered outputs.
- Issue (no stall, no branch): imem_addr = pc. On the clock edge: req_pc <= pc, req_valid <= 1, pc <= pc + 1. The increment is modulo 2^PC_WIDTH, so all-ones wraps to 0.
- Assembly when req_valid:
  - FIRST, imem_rdata[15]=0: complete short instruction. insn_out <= {16'h0, imem_rdata}, insn_pc <= req_pc, insn_long <= 0, insn_valid <= 1.
  - FIRST, imem_rdata[15]=1: lo_word <= imem_rdata, lo_pc <= req_pc, state -> SECOND, insn_valid <= 0.
  - SECOND: insn_out <= {imem_rdata, lo_word}, insn_pc <= lo_pc, insn_long <= 1, insn_valid <= 1, state -> FIRST. Bit 15 of the second word is ignored.
- If req_valid=0, or no instruction completes in a cycle, insn_valid <= 0.
- Stall (stall_in=1, branch_valid=0):
  - All outputs, state, lo_word and lo_pc hold.
  - The arriving word is discarded. pc <= req_valid ? req_pc : pc (rewind to re-fetch that word), and req_valid <= 0.
  - No new issue is counted while stalled.
- Branch (branch_valid=1):
  - pc <= branch_target, req_valid <= 0, state -> FIRST, insn_valid <= 0.
  - The arriving word and any held lo_word are discarded.
  - Branch has priority over stall_in.
- Reset (priority over all):
  - pc <= RESET_VECTOR, req_valid <= 0, state <= FIRST, lo_word <= 0, lo_pc <= 0.
  - insn_out <= 0, insn_pc <= 0, insn_long <= 0, insn_valid <= 0.
  - Reset asserted mid-long-instruction drops the partial instruction.

## Timing
- Every output is registered. Reset values: insn_valid=0, insn_out=0, insn_pc=0, insn_long=0, imem_addr=RESET_VECTOR.
- Memory read latency is 1 cycle: data for the imem_addr presented in cycle n appears on imem_rdata in cycle n+1.
- Taking C0 as the first cycle after reset deasserts:
  - A short instruction at RESET_VECTOR is issued in C0 and shows insn_valid in C2.
  - A long instruction at RESET_VECTOR shows insn_valid in C3.
- Steady-state throughput with no stall: one short instruction per cycle, or one long instruction per 2 cycles.
- Branch sampled in cycle n: branch_target is issued in n+1, and its first valid instruction appears in n+3 (short).
- Stall released in cycle n (stall_in=0 in n): the rewound word is issued in n, arrives in n+1, and its instruction is valid in n+2 at the earliest.
- insn_valid=1 together with stall_in=1 holds every output bit-for-bit until the first cycle with stall_in=0. Outputs then update on that cycle's edge.

## Configuration
- FETCH_LONG_INSN_EN defined:
  - 32-bit assembly behaves as described above.
  - The SECOND state, lo_word and lo_pc are present.
- FETCH_LONG_INSN_EN undefined:
  - Every word is emitted as a short instruction whatever the value of bit 15.
  - insn_long is tied to 0 and insn_out[31:16] to 0.
  - The SECOND state, lo_word and lo_pc are removed.
  - Throughput is one instruction per cycle.

## Test plan
- Reset, then memory words 0x0001, 0x0002, 0x0003 at addresses 0..2 with RESET_VECTOR=0 → insn_valid in C2, C3, C4 with insn_pc 0, 1, 2 and insn_out 0x00000001, 0x00000002, 0x00000003.
- Word 0x8012 at addr 4 and 0x1234 at addr 5 → single insn_valid pulse with insn_out=0x12348012, insn_pc=4, insn_long=1; insn_valid=0 in the preceding cycle.
- stall_in high for 3 cycles while insn_pc=2 is valid → outputs hold value 2 throughout; the next instruction is insn_pc=3 with no address skipped or duplicated.
- branch_valid with branch_target=0x00100 while in SECOND (lo_word pending) → no partial instruction emitted; the next valid instruction has insn_pc=0x00100; branch_valid and stall_in together → the branch wins.
- RESET_VECTOR=20'hFFFFE with short instructions → insn_pc sequence FFFFE, FFFFF, 00000.
- reset asserted for one cycle mid-stream → all outputs 0 on the next cycle; fetch restarts at RESET_VECTOR.
